// File: rtl/alu_seq.sv
// alu_seq: registered, parametrised ALU with a persistent flag register and
// a valid/ready request handshake. Single-cycle ops complete one cycle after
// accept. Rotates by a nonzero amount step one bit per cycle through the ROT
// state. Rotates by zero complete in one cycle like the other ops.
//
// State table:
//   state | meaning
//   IDLE  | ready for a request; single-cycle ops complete from here
//   ROT   | iterative rotate in progress, one bit per cycle
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operation request
//   in_ready   request is accepted this cycle (state == IDLE)
//   op         opcode, sampled on accept
//   a, b       operands; b[SHW-1:0] is the rotate amount for ROL/ROR
//   flag_clr   clears co/z/n unless a completion lands on the same edge
//   out_valid  one-cycle pulse when result and flags are updated
//   result     registered result, held until the next completion
//   co, z, n   registered carry, zero and negative flags, held
//   busy       rotate in progress
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flag_clr,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             co,
  output logic             z,
  output logic             n,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_XOR = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_ADC = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_ROL = 3'b101;
  localparam logic [2:0] OP_ROR = 3'b110;

  typedef enum logic {
    IDLE = 1'b0,
    ROT  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [SHW-1:0]   count_q, count_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic             dir_q, dir_d;      // 1 = rotate right
  logic [WIDTH-1:0] result_q, result_d;
  logic             co_q, co_d;
  logic             z_q, z_d;
  logic             n_q, n_d;
  logic             out_valid_q, out_valid_d;

  logic             accept;
  logic [SHW-1:0]   rot_amt;
  logic             is_rot_op;
  logic             start_rot;
  logic             rot_done;
  logic [WIDTH-1:0] rot_next;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] sc_res;
  logic             sc_co;
  logic             complete;
  logic [WIDTH-1:0] cmp_res;
  logic             cmp_co;

  assign accept    = in_valid && in_ready;
  assign rot_amt   = b[SHW-1:0];
  assign is_rot_op = (op == OP_ROL) || (op == OP_ROR);
  assign start_rot = accept && is_rot_op && (rot_amt != '0);
  assign rot_done  = (state_q == ROT) && (count_q == SHW'(1));

  // One-bit rotate step of the working register
  assign rot_next = dir_q ? {work_q[0], work_q[WIDTH-1:1]}
                          : {work_q[WIDTH-2:0], work_q[WIDTH-1]};

  // Single-cycle result. Rotates reach here only with a zero amount,
  // which passes a through with co cleared.
  always_comb begin
    sum    = '0;
    sc_res = '0;
    sc_co  = 1'b0;
    unique case (op)
      OP_AND: sc_res = a & b;
      OP_XOR: sc_res = a ^ b;
      OP_ADD: begin
        sum    = {1'b0, a} + {1'b0, b};
        sc_res = sum[WIDTH-1:0];
        sc_co  = sum[WIDTH];
      end
      OP_ADC: begin
        sum    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, co_q};
        sc_res = sum[WIDTH-1:0];
        sc_co  = sum[WIDTH];
      end
      OP_SUB: begin
        // Carry out of a + ~b + 1 is set when there is no borrow
        sum    = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
        sc_res = sum[WIDTH-1:0];
        sc_co  = sum[WIDTH];
      end
      OP_ROL, OP_ROR: sc_res = a;
      default: begin
        sc_res = '0;
        sc_co  = 1'b0;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start_rot) state_d = ROT;
      ROT:  if (rot_done)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    unique case (state_q)
      IDLE: in_ready = 1'b1;
      ROT:  busy     = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  // Rotate datapath and completion / flag update
  always_comb begin
    work_d      = work_q;
    count_d     = count_q;
    dir_d       = dir_q;
    result_d    = result_q;
    co_d        = co_q;
    z_d         = z_q;
    n_d         = n_q;

    if (start_rot) begin
      work_d  = a;
      count_d = rot_amt;
      dir_d   = (op == OP_ROR);
    end else if (state_q == ROT) begin
      work_d  = rot_next;
      count_d = count_q - 1'b1;
    end

    // accept and rot_done are mutually exclusive: accept needs IDLE
    complete = (accept && !start_rot) || rot_done;
    cmp_res  = rot_done ? rot_next : sc_res;
    cmp_co   = rot_done ? (dir_q ? rot_next[WIDTH-1] : rot_next[0]) : sc_co;

    // A completion on the same edge as flag_clr takes precedence
    if (complete) begin
      result_d = cmp_res;
      co_d     = cmp_co;
      z_d      = (cmp_res == '0);
      n_d      = cmp_res[WIDTH-1];
    end else if (flag_clr) begin
      co_d = 1'b0;
      z_d  = 1'b0;
      n_d  = 1'b0;
    end

    out_valid_d = complete;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= '0;
      work_q      <= '0;
      dir_q       <= 1'b0;
      result_q    <= '0;
      co_q        <= 1'b0;
      z_q         <= 1'b0;
      n_q         <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      work_q      <= work_d;
      dir_q       <= dir_d;
      result_q    <= result_d;
      co_q        <= co_d;
      z_q         <= z_d;
      n_q         <= n_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign co        = co_q;
  assign z         = z_q;
  assign n         = n_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): directed scenarios followed by
// randomized operations compared against an arithmetic reference model.
module tb_alu_seq;

  localparam int W    = 8;
  localparam int MASK = (1 << W) - 1;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         flag_clr;
  logic         out_valid;
  logic [W-1:0] result;
  logic         co;
  logic         z;
  logic         n;
  logic         busy;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int unsigned m_res = 0;
  bit          m_co  = 0;
  bit          m_z   = 0;
  bit          m_n   = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .a        (a),
    .b        (b),
    .flag_clr (flag_clr),
    .out_valid(out_valid),
    .result   (result),
    .co       (co),
    .z        (z),
    .n        (n),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Arithmetic reference for one operation
  function automatic void ref_op(input int unsigned o, input int unsigned av,
                                 input int unsigned bv, input bit cin,
                                 output int unsigned res, output bit c);
    int unsigned s;
    int unsigned k;
    res = 0;
    c   = 0;
    k   = bv % W;
    case (o)
      0: res = av & bv;
      1: res = av ^ bv;
      2: begin s = av + bv;       res = s & MASK; c = (s > MASK); end
      3: begin s = av + bv + cin; res = s & MASK; c = (s > MASK); end
      4: begin res = (av - bv) & MASK; c = (av >= bv); end
      5: begin
        if (k == 0) res = av;
        else begin
          res = ((av << k) | (av >> (W - k))) & MASK;
          c   = res & 1;
        end
      end
      6: begin
        if (k == 0) res = av;
        else begin
          res = ((av >> k) | (av << (W - k))) & MASK;
          c   = (res >> (W - 1)) & 1;
        end
      end
      default: res = 0;
    endcase
  endfunction

  task automatic check_held(input string tag);
    chk({tag, ".result"}, result, m_res);
    chk({tag, ".co"}, co, m_co);
    chk({tag, ".z"}, z, m_z);
    chk({tag, ".n"}, n, m_n);
  endtask

  // Issue one request, follow it to completion and check timing and values.
  // Returns during the completion cycle, after its negedge.
  task automatic run_op(input string tag, input int unsigned o, input int unsigned av,
                        input int unsigned bv, input bit clr);
    int unsigned res;
    bit          c;
    int unsigned k;
    ref_op(o, av, bv, m_co, res, c);
    k = ((o == 5) || (o == 6)) ? (bv % W) : 0;
    chk({tag, ".ready_pre"}, in_ready, 1);
    in_valid = 1'b1;
    op       = o[2:0];
    a        = av[W-1:0];
    b        = bv[W-1:0];
    flag_clr = clr;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flag_clr = 1'b0;
    if (k != 0 && clr) begin
      m_co = 0; m_z = 0; m_n = 0;
    end
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      chk({tag, ".busy"}, busy, 1);
      chk({tag, ".ready_busy"}, in_ready, 0);
      chk({tag, ".ov_early"}, out_valid, 0);
      if (i == 0) begin
        in_valid = 1'b1;
        op       = 3'b010;
        a        = 8'h11;
        b        = 8'h22;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
    m_res = res;
    m_co  = c;
    m_z   = (res == 0);
    m_n   = (res >> (W - 1)) & 1;
    @(negedge clk);
    chk({tag, ".ov"}, out_valid, 1);
    chk({tag, ".ready"}, in_ready, 1);
    chk({tag, ".busy_done"}, busy, 0);
    check_held(tag);
  endtask

  task automatic idle_cycle(input string tag, input bit clr);
    in_valid = 1'b0;
    flag_clr = clr;
    @(posedge clk);
    #1;
    flag_clr = 1'b0;
    if (clr) begin
      m_co = 0; m_z = 0; m_n = 0;
    end
    @(negedge clk);
    chk({tag, ".ov_idle"}, out_valid, 0);
    check_held(tag);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    op       = '0;
    a        = '0;
    b        = '0;
    flag_clr = 1'b0;

    // Requests during reset are ignored
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b1; op = 3'b010; a = 8'h01; b = 8'h01;
    @(negedge clk);
    chk("rst.ready", in_ready, 1);
    chk("rst.ov", out_valid, 0);
    chk("rst.busy", busy, 0);
    check_held("rst");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);
    check_held("post_rst");
    chk("post_rst.ov", out_valid, 0);

    // Directed scenarios
    run_op("add_f0_20", 2, 8'hF0, 8'h20, 0);
    run_op("and_aa_55", 0, 8'hAA, 8'h55, 0);
    run_op("add_ff_01", 2, 8'hFF, 8'h01, 0);
    run_op("adc_00_00", 3, 8'h00, 8'h00, 0);
    idle_cycle("clr_only", 1);
    run_op("adc_01_01", 3, 8'h01, 8'h01, 0);
    run_op("sub_05_05", 4, 8'h05, 8'h05, 0);
    run_op("sub_03_05", 4, 8'h03, 8'h05, 0);
    run_op("rol_81_3", 5, 8'h81, 3, 0);
    run_op("rol_81_1", 5, 8'h81, 1, 0);
    run_op("ror_01_1", 6, 8'h01, 1, 0);
    run_op("rol_k0", 5, 8'hA5, 8'h08, 0);
    run_op("rsvd", 7, 8'h12, 8'h34, 0);
    run_op("add_ff_01_clr", 2, 8'hFF, 8'h01, 1);
    idle_cycle("hold", 0);

    // Reset in the middle of a rotate
    @(posedge clk);
    #1;
    in_valid = 1'b1; op = 3'b110; a = 8'h01; b = 8'h07;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mid.busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    m_res = 0; m_co = 0; m_z = 0; m_n = 0;
    chk("rst_mid.busy", busy, 0);
    chk("rst_mid.ready", in_ready, 1);
    chk("rst_mid.ov", out_valid, 0);
    check_held("rst_mid");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rst_mid.no_ov", out_valid, 0);
      chk("rst_mid.ready_after", in_ready, 1);
    end
    check_held("rst_mid_after");

    // Randomized operations with occasional idle/flag-clear cycles
    for (int i = 0; i < 300; i++) begin
      int unsigned o;
      int unsigned av;
      int unsigned bv;
      bit          clr;
      o   = $urandom_range(0, 7);
      av  = $urandom_range(0, MASK);
      bv  = $urandom_range(0, MASK);
      clr = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) av = MASK;
      if ($urandom_range(0, 7) == 0) bv = ($urandom_range(0, 1) == 0) ? 0 : MASK;
      run_op("rnd", o, av, bv, clr);
      if ($urandom_range(0, 4) == 0) idle_cycle("rnd_idle", $urandom_range(0, 1) == 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
